// File: rtl/mcast_pkg.sv
// mcast_pkg: port numbering, source encoding and fork-set helpers shared by
// the multicast router and its bench. Data width comes from `DW (params.svh),
// defaulting to 32 bits when it has not been defined.
`ifndef DW
`define DW 32
`endif

package mcast_pkg;

  localparam int P_LOCAL = 0;
  localparam int P_XN    = 1;
  localparam int P_XP    = 2;
  localparam int P_YN    = 3;
  localparam int P_YP    = 4;
  localparam int NPORT   = P_YP + 1;

  localparam logic [2:0] SRC_NONE = 3'd7;

  // Mask of outputs whose source field selects input i.
  function automatic logic [NPORT-1:0] fork_set(input logic [3*NPORT-1:0] output_src,
                                                input int i);
    logic [NPORT-1:0] mask;
    mask = '0;
    for (int o = 0; o < NPORT; o++) begin
      if (output_src[3*o +: 3] == 3'(i)) mask[o] = 1'b1;
    end
    return mask;
  endfunction

  // Source input index feeding output o (values >= NPORT mean unused).
  function automatic logic [2:0] src_of(input logic [3*NPORT-1:0] output_src,
                                        input int o);
    return output_src[3*o +: 3];
  endfunction

endpackage

// File: rtl/mcast_fifo.sv
// mcast_fifo: small synchronous FIFO with asynchronous active-high reset.
// The head entry is always visible; full/empty come straight from the
// registered count so the router's ready and valid never see a bypass path.
module mcast_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy; storage is cleared on reset so
  // nothing stale can reach the outputs while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/multicast_router.sv
// multicast_router: one mesh node of the scatter network. Each input owns a
// FIFO whose head is replicated onto the outputs that name it in output_src.
// Branches complete independently; a served mask per input stops duplicates
// and the head pops once every branch has taken it.
// Optional feature macro: MCAST_DROP_UNROUTED_EN (unrouted inputs accept and
// discard flits, counted on drop_cnt).
`ifndef DW
`define DW 32
`endif

module multicast_router
  import mcast_pkg::*;
#(
  parameter logic [3*NPORT-1:0] output_src = 15'h7FFF,
  parameter int                 FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [`DW-1:0]   data_i  [NPORT],
  input  logic [NPORT-1:0] valid_i,
  output logic [NPORT-1:0] ready_o,
  output logic [`DW-1:0]   data_o  [NPORT],
  output logic [NPORT-1:0] valid_o,
  input  logic [NPORT-1:0] ready_i
`ifdef MCAST_DROP_UNROUTED_EN
  ,
  output logic [31:0]      drop_cnt
`endif
);

`ifdef MCAST_DROP_UNROUTED_EN
  localparam logic DROP_UNROUTED = 1'b1;
`else
  localparam logic DROP_UNROUTED = 1'b0;
`endif

  logic [`DW-1:0]   head    [NPORT];
  logic [NPORT-1:0] served  [NPORT];
  logic [NPORT-1:0] xfer_in [NPORT];
  logic [NPORT-1:0] full;
  logic [NPORT-1:0] empty;
  logic [NPORT-1:0] push;
  logic [NPORT-1:0] pop;
  logic [NPORT-1:0] routed;
  logic [NPORT-1:0] xfer;

  assign xfer = valid_o & ready_i;

  for (genvar i = 0; i < NPORT; i++) begin : g_in
    localparam logic [NPORT-1:0] FSET = fork_set(output_src, i);

    assign routed[i]  = |FSET;
    assign xfer_in[i] = xfer & FSET;
    assign ready_o[i] = ~rst & ((FSET != '0) ? ~full[i] : DROP_UNROUTED);
    assign push[i]    = routed[i] & valid_i[i] & ready_o[i];
    assign pop[i]     = routed[i] & ~empty[i] & (&(~FSET | served[i] | xfer_in[i]));

    mcast_fifo #(
      .DW    (`DW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (data_i[i]),
      .head  (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_out
    localparam logic [2:0] S = src_of(output_src, o);
    if (S < NPORT) begin : g_used
      assign valid_o[o] = ~empty[S] & ~served[S][o];
      assign data_o[o]  = head[S];
    end else begin : g_unused
      assign valid_o[o] = 1'b0;
      assign data_o[o]  = '0;
    end
  end

  // Record which branches already took each head; clear when the head pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPORT; i++) served[i] <= '0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (pop[i]) served[i] <= '0;
        else        served[i] <= served[i] | xfer_in[i];
      end
    end
  end

`ifdef MCAST_DROP_UNROUTED_EN
  logic [NPORT-1:0] drop;
  logic [2:0]       drop_n;
  logic [32:0]      drop_sum;

  assign drop     = ~routed & valid_i & ready_o;
  assign drop_sum = {1'b0, drop_cnt} + {30'b0, drop_n};

  // Number of flits discarded this cycle across all unrouted inputs.
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < NPORT; i++) drop_n = drop_n + {2'b0, drop[i]};
  end

  // Saturating count of discarded flits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              drop_cnt <= '0;
    else if (drop_sum[32]) drop_cnt <= '1;
    else                  drop_cnt <= drop_sum[31:0];
  end
`endif

endmodule

// File: tb/tb_multicast_router.sv
// tb_multicast_router: table-driven unicast and broadcast checks, hand-built
// unrouted-input and mid-fork reset sequences, and a randomized two-stream
// run compared against per-output expected-flit queues.
`ifndef DW
`define DW 32
`endif

module tb_multicast_router;
  import mcast_pkg::*;

  localparam int DW    = `DW;
  localparam int DEPTH = 2;
  localparam logic [14:0] SRC_UNI = 15'h7E3F;  // 0 -> 2
  localparam logic [14:0] SRC_BC  = 15'h0007;  // 0 -> {1,2,3,4}
  localparam logic [14:0] SRC_CC  = 15'h7E39;  // 0 -> 2, 1 -> 0
`ifdef MCAST_DROP_UNROUTED_EN
  localparam logic UNROUTED_RDY = 1'b1;
`else
  localparam logic UNROUTED_RDY = 1'b0;
`endif

  typedef struct {
    logic             vin;
    logic [DW-1:0]    din;
    logic [NPORT-1:0] rdy;
    logic             exp_rdy;
    logic [NPORT-1:0] exp_vo;
    logic [DW-1:0]    exp_do;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  logic [DW-1:0]    din_a [NPORT], do_a [NPORT];
  logic [NPORT-1:0] vin_a, rdy_o_a, vo_a, rdy_i_a;
  logic [DW-1:0]    din_b [NPORT], do_b [NPORT];
  logic [NPORT-1:0] vin_b, rdy_o_b, vo_b, rdy_i_b;
  logic [DW-1:0]    din_c [NPORT], do_c [NPORT];
  logic [NPORT-1:0] vin_c, rdy_o_c, vo_c, rdy_i_c;
`ifdef MCAST_DROP_UNROUTED_EN
  logic [31:0] drop_a, drop_b, drop_c;
`endif

  int n_cmp;
  int n_bad;

  vec_t uni_tab [12];
  vec_t bc_tab  [7];

  always #5 clk = ~clk;

  multicast_router #(.output_src(SRC_UNI), .FIFO_DEPTH(DEPTH)) u_a (
    .clk(clk), .rst(rst), .data_i(din_a), .valid_i(vin_a), .ready_o(rdy_o_a),
    .data_o(do_a), .valid_o(vo_a), .ready_i(rdy_i_a)
`ifdef MCAST_DROP_UNROUTED_EN
    , .drop_cnt(drop_a)
`endif
  );

  multicast_router #(.output_src(SRC_BC), .FIFO_DEPTH(DEPTH)) u_b (
    .clk(clk), .rst(rst), .data_i(din_b), .valid_i(vin_b), .ready_o(rdy_o_b),
    .data_o(do_b), .valid_o(vo_b), .ready_i(rdy_i_b)
`ifdef MCAST_DROP_UNROUTED_EN
    , .drop_cnt(drop_b)
`endif
  );

  multicast_router #(.output_src(SRC_CC), .FIFO_DEPTH(DEPTH)) u_c (
    .clk(clk), .rst(rst), .data_i(din_c), .valid_i(vin_c), .ready_o(rdy_o_c),
    .data_o(do_c), .valid_o(vo_c), .ready_i(rdy_i_c)
`ifdef MCAST_DROP_UNROUTED_EN
    , .drop_cnt(drop_c)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    vin_a = '0; vin_b = '0; vin_c = '0;
    rdy_i_a = '0; rdy_i_b = '0; rdy_i_c = '0;
    for (int k = 0; k < NPORT; k++) begin
      din_a[k] = '0; din_b[k] = '0; din_c[k] = '0;
    end
  endtask

  task automatic applyStimulus(input int sel, input vec_t v);
    if (sel == 0) begin
      vin_a = '0; vin_a[0] = v.vin; din_a[0] = v.din; rdy_i_a = v.rdy;
    end else begin
      vin_b = '0; vin_b[0] = v.vin; din_b[0] = v.din; rdy_i_b = v.rdy;
    end
  endtask

  task automatic checkVector(input int sel, input string tag, input int k, input vec_t v);
    logic [NPORT-1:0] ro, vo;
    logic [DW-1:0]    dq [NPORT];
    if (sel == 0) begin
      ro = rdy_o_a; vo = vo_a; dq = do_a;
    end else begin
      ro = rdy_o_b; vo = vo_b; dq = do_b;
    end
    checkOutput($sformatf("%s[%0d].ready", tag, k), 64'(ro[0]), 64'(v.exp_rdy));
    checkOutput($sformatf("%s[%0d].valid", tag, k), 64'(vo), 64'(v.exp_vo));
    for (int o = 0; o < NPORT; o++) begin
      if (v.exp_vo[o])
        checkOutput($sformatf("%s[%0d].data%0d", tag, k, o), 64'(dq[o]), 64'(v.exp_do));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // unicast 0 -> 2, including a stall that fills the FIFO
    uni_tab[0]  = '{1'b1, 'h11, 5'b11111, 1'b1, 5'b00000, 'h0};
    uni_tab[1]  = '{1'b1, 'h12, 5'b11111, 1'b1, 5'b00100, 'h11};
    uni_tab[2]  = '{1'b1, 'h13, 5'b11111, 1'b1, 5'b00100, 'h12};
    uni_tab[3]  = '{1'b1, 'h14, 5'b11111, 1'b1, 5'b00100, 'h13};
    uni_tab[4]  = '{1'b0, 'h0,  5'b11111, 1'b1, 5'b00100, 'h14};
    uni_tab[5]  = '{1'b1, 'h21, 5'b11011, 1'b1, 5'b00000, 'h0};
    uni_tab[6]  = '{1'b1, 'h22, 5'b11011, 1'b1, 5'b00100, 'h21};
    uni_tab[7]  = '{1'b1, 'h23, 5'b11011, 1'b0, 5'b00100, 'h21};
    uni_tab[8]  = '{1'b1, 'h23, 5'b11111, 1'b0, 5'b00100, 'h21};
    uni_tab[9]  = '{1'b1, 'h23, 5'b11111, 1'b1, 5'b00100, 'h22};
    uni_tab[10] = '{1'b0, 'h0,  5'b11111, 1'b1, 5'b00100, 'h23};
    uni_tab[11] = '{1'b0, 'h0,  5'b11111, 1'b1, 5'b00000, 'h0};

    // broadcast 0 -> {1,2,3,4}, branch 3 stalled for three cycles
    bc_tab[0] = '{1'b1, 'hA, 5'b10111, 1'b1, 5'b00000, 'h0};
    bc_tab[1] = '{1'b1, 'hB, 5'b10111, 1'b1, 5'b11110, 'hA};
    bc_tab[2] = '{1'b0, 'h0, 5'b10111, 1'b0, 5'b01000, 'hA};
    bc_tab[3] = '{1'b0, 'h0, 5'b10111, 1'b0, 5'b01000, 'hA};
    bc_tab[4] = '{1'b0, 'h0, 5'b11111, 1'b0, 5'b01000, 'hA};
    bc_tab[5] = '{1'b0, 'h0, 5'b11111, 1'b1, 5'b11110, 'hB};
    bc_tab[6] = '{1'b0, 'h0, 5'b11111, 1'b1, 5'b00000, 'h0};

    rst = 1'b1;
    clearInputs();
    #12;
    checkOutput("reset.ready_a", 64'(rdy_o_a), 64'(0));
    checkOutput("reset.valid_a", 64'(vo_a), 64'(0));
    checkOutput("reset.ready_b", 64'(rdy_o_b), 64'(0));
    checkOutput("reset.valid_c", 64'(vo_c), 64'(0));
    checkOutput("reset.data_a2", 64'(do_a[2]), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, uni_tab[k]);
      #3;
      checkVector(0, "uni", k, uni_tab[k]);
      @(posedge clk); #1;
    end
    clearInputs();

    for (int k = 0; k < 7; k++) begin
      applyStimulus(1, bc_tab[k]);
      #3;
      checkVector(1, "bcast", k, bc_tab[k]);
      @(posedge clk); #1;
    end
    clearInputs();

    // unrouted input 4 on the broadcast node
    for (int k = 0; k < 10; k++) begin
      vin_b = 5'b10000;
      din_b[4] = DW'($urandom);
      rdy_i_b = '1;
      #3;
      checkOutput($sformatf("unrouted[%0d].ready4", k), 64'(rdy_o_b[4]), 64'(UNROUTED_RDY));
      checkOutput($sformatf("unrouted[%0d].valid", k), 64'(vo_b), 64'(0));
      @(posedge clk); #1;
    end
    clearInputs();
`ifdef MCAST_DROP_UNROUTED_EN
    #3;
    checkOutput("unrouted.drop_cnt", 64'(drop_b), 64'(10));
    @(posedge clk); #1;
`endif

    // reset while a fork is half served
    vin_b[0] = 1'b1;
    din_b[0] = 'hC;
    #3;
    checkOutput("midrst.accept", 64'(rdy_o_b[0]), 64'(1));
    @(posedge clk); #1;
    vin_b = '0;
    rdy_i_b = 5'b00010;
    #3;
    checkOutput("midrst.present", 64'(vo_b), 64'(5'b11110));
    @(posedge clk); #1;
    rdy_i_b = '0;
    #3;
    checkOutput("midrst.served", 64'(vo_b), 64'(5'b11100));
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst.valid_b", 64'(vo_b), 64'(0));
    checkOutput("midrst.ready_b", 64'(rdy_o_b), 64'(0));
    checkOutput("midrst.valid_a", 64'(vo_a), 64'(0));
    for (int o = 0; o < NPORT; o++)
      checkOutput($sformatf("midrst.data%0d", o), 64'(do_b[o]), 64'(0));
`ifdef MCAST_DROP_UNROUTED_EN
    checkOutput("midrst.drop_cnt", 64'(drop_b), 64'(0));
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rdy_i_b = '1;
      #3;
      checkOutput($sformatf("postrst[%0d].valid", k), 64'(vo_b), 64'(0));
      checkOutput($sformatf("postrst[%0d].ready0", k), 64'(rdy_o_b[0]), 64'(1));
      @(posedge clk); #1;
    end
    clearInputs();

    // two independent random streams: input 0 -> output 2, input 1 -> output 0
    begin
      logic [DW-1:0] q0[$];
      logic [DW-1:0] q1[$];
      int tag0;
      int tag1;
      tag0 = 0;
      tag1 = 0;
      for (int cyc = 0; cyc < 340; cyc++) begin
        int s0;
        int s1;
        logic drain;
        logic [NPORT-1:0] exp_vo, exp_ro;
        drain = (cyc >= 300);
        s0 = q0.size();
        s1 = q1.size();
        vin_c = '0;
        if (!drain) begin
          vin_c[0] = 1'($urandom_range(0, 1));
          vin_c[1] = 1'($urandom_range(0, 1));
          rdy_i_c  = NPORT'($urandom);
        end else begin
          rdy_i_c = '1;
        end
        din_c[0] = DW'(32'hA000_0000 + tag0);
        din_c[1] = DW'(32'hB000_0000 + tag1);
        #3;
        exp_vo = {2'b00, s0 != 0, 1'b0, s1 != 0};
        exp_ro = {{3{UNROUTED_RDY}}, s1 < DEPTH, s0 < DEPTH};
        checkOutput($sformatf("rand[%0d].valid", cyc), 64'(vo_c), 64'(exp_vo));
        checkOutput($sformatf("rand[%0d].ready", cyc), 64'(rdy_o_c), 64'(exp_ro));
        if (s0 != 0) checkOutput($sformatf("rand[%0d].data2", cyc), 64'(do_c[2]), 64'(q0[0]));
        if (s1 != 0) checkOutput($sformatf("rand[%0d].data0", cyc), 64'(do_c[0]), 64'(q1[0]));
        if (s0 != 0 && rdy_i_c[2]) void'(q0.pop_front());
        if (s1 != 0 && rdy_i_c[0]) void'(q1.pop_front());
        if (vin_c[0] && s0 < DEPTH) begin q0.push_back(din_c[0]); tag0++; end
        if (vin_c[1] && s1 < DEPTH) begin q1.push_back(din_c[1]); tag1++; end
        @(posedge clk); #1;
        if (drain && q0.size() == 0 && q1.size() == 0) break;
      end
      checkOutput("rand.drained", 64'(q0.size() + q1.size()), 64'(0));
      #3;
      checkOutput("rand.idle", 64'(vo_c), 64'(0));
    end
    clearInputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
